// File: rtl/i2c_target_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_target_if : I2C pins and register-side signals of i2c_target     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface i2c_target_if;
  logic       scl;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rd_data;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       reg_wr;
  logic       busy;
  logic [3:0] state_info;

  modport master (
    output scl, sda_in, rd_data,
    input  sda_oe, reg_addr, reg_data, reg_wr, busy, state_info
  );

  modport slave (
    input  scl, sda_in, rd_data,
    output sda_oe, reg_addr, reg_data, reg_wr, busy, state_info
  );
endinterface
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_target : I2C target turning byte pairs into register writes      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'b0011010
) (
  input  wire logic   clk,
  input  wire logic   reset,
  i2c_target_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ADDR     = 4'd1,
    S_ADDR_ACK = 4'd2,
    S_BYTE0    = 4'd3,
    S_ACK0     = 4'd4,
    S_BYTE1    = 4'd5,
    S_ACK1     = 4'd6,
    S_RD_TX    = 4'd7,
    S_RD_ACK   = 4'd8,
    S_IGNORE   = 4'd15
  } state_t;

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_d;
  logic       r_sda_d;

  // Synchronizers idle high so leaving reset never looks like a bus event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], bus.scl};
      r_sda_sync <= {r_sda_sync[0], bus.sda_in};
      r_scl_d    <= r_scl_sync[1];
      r_sda_d    <= r_sda_sync[1];
    end
  end

  logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl      = r_scl_sync[1];
  assign w_sda      = r_sda_sync[1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  state_t     r_state, w_state_nx;
  logic [3:0] r_cnt, w_cnt_nx;
  logic [7:0] r_shift, w_shift_nx, w_shift_in;
  logic [7:0] r_byte0, w_byte0_nx;
  logic [7:0] r_tx, w_tx_nx;
  logic       r_sda_oe, w_oe_nx;
  logic       r_busy, w_busy_nx;
  logic [6:0] r_reg_addr, w_addr_nx;
  logic [8:0] r_reg_data, w_data_nx;
  logic       r_reg_wr, w_wr_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_shift    <= 8'd0;
      r_byte0    <= 8'd0;
      r_tx       <= 8'd0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_reg_addr <= 7'd0;
      r_reg_data <= 9'd0;
      r_reg_wr   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_shift    <= w_shift_nx;
      r_byte0    <= w_byte0_nx;
      r_tx       <= w_tx_nx;
      r_sda_oe   <= w_oe_nx;
      r_busy     <= w_busy_nx;
      r_reg_addr <= w_addr_nx;
      r_reg_data <= w_data_nx;
      r_reg_wr   <= w_wr_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_shift_nx = r_shift;
    w_byte0_nx = r_byte0;
    w_tx_nx    = r_tx;
    w_oe_nx    = r_sda_oe;
    w_busy_nx  = r_busy;
    w_addr_nx  = r_reg_addr;
    w_data_nx  = r_reg_data;
    w_wr_nx    = 1'b0;
    w_shift_in = {r_shift[6:0], w_sda};

    // Bus conditions win over any scl edge decoded in the same cycle.
    if (w_start) begin
      w_state_nx = S_ADDR;
      w_cnt_nx   = 4'd0;
      w_shift_nx = 8'd0;
      w_oe_nx    = 1'b0;
      w_busy_nx  = 1'b1;
    end else if (w_stop) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = 4'd0;
      w_oe_nx    = 1'b0;
      w_busy_nx  = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_BYTE0, S_BYTE1: begin
          if (w_scl_rise) begin
            w_shift_nx = w_shift_in;
            w_cnt_nx   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nx = 4'd0;
              if (r_state == S_ADDR) begin
                w_state_nx = (w_shift_in[7:1] == TARGET_ADDR) ? S_ADDR_ACK : S_IGNORE;
              end else if (r_state == S_BYTE0) begin
                w_state_nx = S_ACK0;
                w_byte0_nx = w_shift_in;
              end else begin
                w_state_nx = S_ACK1;
                w_wr_nx    = 1'b1;
                w_addr_nx  = r_byte0[7:1];
                w_data_nx  = {r_byte0[0], w_shift_in};
              end
            end
          end
        end

        // r_cnt: 0 = waiting for the fall that starts ACK, 1 = 9th bit clocked.
        S_ADDR_ACK, S_ACK0, S_ACK1: begin
          if (w_scl_rise) begin
            w_cnt_nx = 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd0) begin
              w_oe_nx = 1'b1;
            end else begin
              w_oe_nx    = 1'b0;
              w_cnt_nx   = 4'd0;
              w_shift_nx = 8'd0;
              if (r_state == S_ADDR_ACK && r_shift[0]) begin
                w_state_nx = S_RD_TX;
                w_tx_nx    = bus.rd_data;
                w_oe_nx    = ~bus.rd_data[7];
              end else if (r_state == S_ACK0) begin
                w_state_nx = S_BYTE1;
              end else begin
                w_state_nx = S_BYTE0;
              end
            end
          end
        end

        S_RD_TX: begin
          if (w_scl_rise) begin
            w_cnt_nx = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_oe_nx    = 1'b0;
              w_cnt_nx   = 4'd0;
              w_state_nx = S_RD_ACK;
            end else begin
              w_oe_nx = ~r_tx[6];
              w_tx_nx = {r_tx[6:0], 1'b0};
            end
          end
        end

        S_RD_ACK: begin
          if (w_scl_rise) begin
            if (w_sda) w_state_nx = S_IGNORE;
            else       w_cnt_nx   = 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd1) begin
            w_state_nx = S_RD_TX;
            w_cnt_nx   = 4'd0;
            w_tx_nx    = bus.rd_data;
            w_oe_nx    = ~bus.rd_data[7];
          end
        end

        S_IDLE, S_IGNORE: begin
          w_oe_nx = 1'b0;
        end

        default: begin
          w_state_nx = S_IDLE;
          w_oe_nx    = 1'b0;
          w_cnt_nx   = 4'd0;
        end
      endcase
    end
  end

  assign bus.sda_oe     = r_sda_oe;
  assign bus.reg_addr   = r_reg_addr;
  assign bus.reg_data   = r_reg_data;
  assign bus.reg_wr     = r_reg_wr;
  assign bus.busy       = r_busy;
  assign bus.state_info = r_state;

endmodule
`default_nettype wire

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 TARGET_ADDR, default 7'b0011010, 7-bit address this target answers to.
REQ-002 clk  input  1  system clock; all logic is synchronous to the rising edge of clk.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 scl  input  1  I2C clock from the bus; asynchronous to clk.
REQ-005 sda_in  input  1  I2C data as seen on the bus; asynchronous to clk.
REQ-006 sda_oe  output  1  open-drain drive: 1 pulls SDA low, 0 releases it.
REQ-007 rd_data  input  8  byte returned to the controller on a read transfer.
REQ-008 reg_addr  output  7  register address of the last completed write pair.
REQ-009 reg_data  output  9  register value of the last completed write pair.
REQ-010 reg_wr  output  1  one-clk strobe; reg_addr and reg_data are valid in the same cycle.
REQ-011 busy  output  1  high from START detection until STOP detection.
REQ-012 state_info  output  4  current FSM state encoding.

Function
REQ-013 The block SHALL pass scl and sda_in through 2-flop synchronizers, then keep a 1-cycle history of each synchronized value for edge detection.
- Edges are therefore detected 3 clk after a pin change.
REQ-014 Bus events SHALL be decoded as follows:
- START: sda falling while scl is high.
- STOP: sda rising while scl is high.
- Data bits are sampled on the scl rising edge.
- sda_oe changes only on the scl falling edge, or on STOP/START/reset.
REQ-015 FSM states and encodings: IDLE=0, ADDR=1, ADDR_ACK=2, BYTE0=3, ACK0=4, BYTE1=5, ACK1=6, RD_TX=7, RD_ACK=8, IGNORE=15.
REQ-016 START from any state SHALL go to ADDR, clear the bit counter, and release sda_oe; this includes repeated START.
REQ-017 STOP from any state SHALL go to IDLE, release sda_oe, and clear busy.
REQ-018 ADDR SHALL shift 8 bits, MSB first. After the 8th rising edge:
- On a match of bits [7:1] with TARGET_ADDR, go to ADDR_ACK.
- On a mismatch, go to IGNORE with sda_oe held at 0.
REQ-019 In every ACK state the target drives the ACK bit:
- sda_oe=1 from the scl falling edge after the 8th bit.
- Released on the scl falling edge after the 9th bit.
REQ-020 After ADDR_ACK, the R/W bit selects the next state: R/W=0 goes to BYTE0, R/W=1 goes to RD_TX.
REQ-021 BYTE0 and BYTE1 each shift 8 bits and then go to ACK0 and ACK1 respectively.
REQ-022 ACK1 SHALL return to BYTE0, so a further byte pair is accepted as a new register write.
REQ-023 reg_wr SHALL pulse for exactly 1 clk, 1 clk after the 8th bit of BYTE1 is sampled, with:
- reg_addr = byte0[7:1]
- reg_data = {byte0[0], byte1}
REQ-024 reg_addr and reg_data SHALL hold their values between strobes.
REQ-025 RD_TX SHALL latch rd_data on the scl falling edge that ends ADDR_ACK (or RD_ACK).
- It presents bits MSB first with sda_oe = ~bit, each bit changing on an scl falling edge.
- It releases SDA on the falling edge after the 8th bit.
REQ-026 RD_ACK SHALL sample the controller's bit on the 9th rising edge: 0 (ACK) returns to RD_TX with a fresh rd_data latch; 1 (NACK) goes to IGNORE.
REQ-027 IGNORE SHALL keep sda_oe=0 and wait for START or STOP.
REQ-028 A STOP or START after BYTE0 but before the 8th bit of BYTE1 SHALL discard the partial pair and produce no reg_wr.
REQ-029 A START and STOP in the same clk cannot occur; an scl edge coincident with a START/STOP decode SHALL be ignored for bit counting.

Reset
REQ-030 While reset is asserted, the outputs SHALL be:
- state=IDLE
- sda_oe=0
- reg_wr=0
- busy=0
- reg_addr=0
- reg_data=0
- bit counter and shift register cleared
REQ-031 Reset mid-transfer SHALL release SDA immediately (asynchronously), and the block SHALL ignore bus traffic until the next START.

Verification
REQ-032 Write addr 0x34 (0x1A+W), bytes 0x1E, 0x00 -> ACK (sda_oe=1) in all three 9th clocks, one reg_wr with reg_addr=0x0F and reg_data=0x000, then IDLE after STOP.
REQ-033 Write to addr 0x36 (0x1B+W) -> sda_oe stays 0 for the whole transfer, state=IGNORE, no reg_wr.
REQ-034 Read 0x35 with rd_data=0xA5 and a controller NACK -> SDA carries 1,0,1,0,0,1,0,1 on the rising edges, state goes to IGNORE, then IDLE on STOP.
REQ-035 Write 0x34, 0x12, then STOP -> ACKs on both bytes, no reg_wr, busy falls at STOP.
REQ-036 Write 0x34, 0x10, 0x55, repeated START, 0x34, 0x0E, 0x02 -> two reg_wr: (0x08, 0x055), then (0x07, 0x002).
REQ-037 Assert reset during ADDR_ACK -> sda_oe=0 in the same cycle, state=IDLE, and no ACK on the following scl pulses until a new START.
